// File: rtl/ntt_pkg.sv
// ntt_pkg: stage codes, transform constants and the stage sequencing rule
// shared by the NTT/INTT control path.
package ntt_pkg;

    localparam int N = 16;
    localparam int LOG2N = 4;
    localparam int INV_TW_OFFSET = 8;

    typedef enum logic [2:0] {
        S_BF0  = 3'd0,
        S_BF1  = 3'd1,
        S_BF2  = 3'd2,
        S_BF3  = 3'd3,
        S_OUT  = 3'd4,
        S_IDLE = 3'd5
    } stage_e;

    // Forward passes walk the stages upward, inverse passes walk them downward.
    // Illegal codes expect a return to idle.
    function automatic logic [2:0] next_stage(input logic [2:0] cur, input logic mode);
        case (cur)
            S_IDLE:  return mode ? S_BF3 : S_BF0;
            S_BF0:   return mode ? S_OUT : S_BF1;
            S_BF1:   return mode ? S_BF0 : S_BF2;
            S_BF2:   return mode ? S_BF1 : S_BF3;
            S_BF3:   return mode ? S_BF2 : S_OUT;
            S_OUT:   return S_IDLE;
            default: return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ntt_stage_decoder.sv
// ntt_stage_decoder: registered datapath enables, butterfly span and twiddle
// base per NTT stage, plus a sticky stage-sequence checker and transform counter.
module ntt_stage_decoder
    import ntt_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic             inv,
    output logic             load_en,
    output logic             bf_en,
    output logic             out_en,
    output logic             scale_en,
    output logic             gs_mode,
    output logic [LOG2N-1:0] span,
    output logic [3:0]       tw_base,
    output logic             done,
    output logic             seq_err,
    output logic [7:0]       tx_count
);

    logic       mode;
    logic       armed;
    logic [2:0] prev_state;
    logic       mode_n;
    logic       is_bf;
    logic       illegal;
    logic       mismatch;
    logic       finish;
    logic [3:0] pow2;

    // Mode is only captured while idle so a late inv change cannot corrupt a pass.
    always_comb begin
        mode_n   = (state == S_IDLE) ? inv : mode;
        is_bf    = state <= S_BF3;
        illegal  = state > S_IDLE;
        pow2     = 4'd1 << state[1:0];
        mismatch = armed && (state != next_stage(prev_state, mode));
        finish   = armed && (prev_state == S_OUT) && (state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= 1'b0;
            armed      <= 1'b0;
            prev_state <= S_IDLE;
            load_en    <= 1'b0;
            bf_en      <= 1'b0;
            out_en     <= 1'b0;
            scale_en   <= 1'b0;
            gs_mode    <= 1'b0;
            span       <= '0;
            tw_base    <= '0;
            done       <= 1'b0;
            seq_err    <= 1'b0;
            tx_count   <= '0;
        end else begin
            mode       <= mode_n;
            armed      <= armed | (state == S_IDLE);
            prev_state <= state;
            load_en    <= state == S_IDLE;
            bf_en      <= is_bf;
            out_en     <= state == S_OUT;
            scale_en   <= (state == S_OUT) && mode_n;
            gs_mode    <= mode_n;
            span       <= is_bf ? pow2 : '0;
            tw_base    <= is_bf ? (mode_n ? 4'(INV_TW_OFFSET) : 4'd0) + pow2 - 4'd1 : '0;
            done       <= finish;
            seq_err    <= seq_err | mismatch | illegal;
            tx_count   <= tx_count + {7'd0, finish};
        end
    end

endmodule

// File: tb/tb_ntt_stage_decoder.sv
// tb_ntt_stage_decoder: table-driven and hand-sequenced checks of the stage
// decoder against an independent lookup-table model via a scoreboard queue.
module tb_ntt_stage_decoder;

    typedef struct packed {
        logic       ld;
        logic       bf;
        logic       oe;
        logic       sc;
        logic       gs;
        logic [3:0] span;
        logic [3:0] tw;
        logic       dn;
        logic       err;
        logic [7:0] tx;
    } outs_t;

    typedef struct {
        logic       r;
        logic [2:0] s;
        logic       i;
        outs_t      e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inv = 1'b0;
    logic [2:0] state = 3'd5;
    logic       load_en, bf_en, out_en, scale_en, gs_mode, done, seq_err;
    logic [3:0] span, tw_base;
    logic [7:0] tx_count;

    int errs = 0;
    int checks = 0;

    outs_t sb[$];
    vec_t  tab[$];

    logic [3:0] span_lut [0:3] = '{4'd1, 4'd2, 4'd4, 4'd8};
    logic [3:0] twf_lut  [0:3] = '{4'd0, 4'd1, 4'd3, 4'd7};
    logic [3:0] twi_lut  [0:3] = '{4'd8, 4'd9, 4'd11, 4'd15};
    logic [2:0] fwd_next [0:5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0] inv_next [0:5] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd5, 3'd3};

    logic       m_mode = 1'b0;
    logic       m_armed = 1'b0;
    logic       m_err = 1'b0;
    logic [2:0] m_prev = 3'd5;
    logic [7:0] m_tx = 8'd0;

    ntt_stage_decoder #(.N(16)) dut (
        .clk(clk), .rst(rst), .state(state), .inv(inv),
        .load_en(load_en), .bf_en(bf_en), .out_en(out_en), .scale_en(scale_en),
        .gs_mode(gs_mode), .span(span), .tw_base(tw_base), .done(done),
        .seq_err(seq_err), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic model(input logic r, input logic [2:0] s, input logic i, output outs_t e);
        logic       nm;
        logic [2:0] want;
        e = '0;
        if (r) begin
            m_mode = 1'b0; m_prev = 3'd5; m_armed = 1'b0; m_err = 1'b0; m_tx = 8'd0;
            return;
        end
        nm = (s == 3'd5) ? i : m_mode;
        if (s > 3'd5) m_err = 1'b1;
        if (m_armed && m_prev <= 3'd5) begin
            want = m_mode ? inv_next[m_prev] : fwd_next[m_prev];
            if (s != want) m_err = 1'b1;
        end
        e.dn = m_armed && m_prev == 3'd4 && s == 3'd5;
        if (e.dn) m_tx = m_tx + 8'd1;
        e.ld = s == 3'd5;
        e.bf = s < 3'd4;
        e.oe = s == 3'd4;
        e.sc = s == 3'd4 && nm;
        e.gs = nm;
        if (s < 3'd4) begin
            e.span = span_lut[s[1:0]];
            e.tw = nm ? twi_lut[s[1:0]] : twf_lut[s[1:0]];
        end
        e.err = m_err;
        e.tx = m_tx;
        m_mode = nm;
        m_prev = s;
        if (s == 3'd5) m_armed = 1'b1;
    endtask

    task automatic cyc(input string nm, input logic r, input logic [2:0] s, input logic i,
                       input bit use_tab, input outs_t te);
        outs_t m, exp, got;
        @(negedge clk);
        rst = r; state = s; inv = i;
        model(r, s, i, m);
        sb.push_back(use_tab ? te : m);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        got = '{load_en, bf_en, out_en, scale_en, gs_mode, span, tw_base, done, seq_err, tx_count};
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s st=%0d: got %h need %h", nm, s, got, exp);
        end
    endtask

    task automatic step(input string nm, input logic [2:0] s);
        cyc(nm, 1'b0, s, 1'b0, 1'b0, '0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d need %0d", nm, got, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic [2:0] s, input logic i,
                               input logic ld, input logic bf, input logic oe, input logic sc,
                               input logic gs, input logic [3:0] sp, input logic [3:0] tw,
                               input logic dn, input logic er, input logic [7:0] tx);
        vec_t x;
        x.r = r; x.s = s; x.i = i;
        x.e = '{ld, bf, oe, sc, gs, sp, tw, dn, er, tx};
        return x;
    endfunction

    initial begin
        // forward pass
        tab.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tab.push_back(v(0, 1, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0, 0));
        tab.push_back(v(0, 2, 0, 0, 1, 0, 0, 0, 4, 3, 0, 0, 0));
        tab.push_back(v(0, 3, 0, 0, 1, 0, 0, 0, 8, 7, 0, 0, 0));
        tab.push_back(v(0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        // inverse pass
        tab.push_back(v(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 3, 1, 0, 1, 0, 0, 1, 8, 15, 0, 0, 0));
        tab.push_back(v(0, 2, 1, 0, 1, 0, 0, 1, 4, 11, 0, 0, 0));
        tab.push_back(v(0, 1, 1, 0, 1, 0, 0, 1, 2, 9, 0, 0, 0));
        tab.push_back(v(0, 0, 1, 0, 1, 0, 0, 1, 1, 8, 0, 0, 0));
        tab.push_back(v(0, 4, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        // inverse pass with inv dropping mid-transform
        tab.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 3, 1, 0, 1, 0, 0, 1, 8, 15, 0, 0, 0));
        tab.push_back(v(0, 2, 0, 0, 1, 0, 0, 1, 4, 11, 0, 0, 0));
        tab.push_back(v(0, 1, 0, 0, 1, 0, 0, 1, 2, 9, 0, 0, 0));
        tab.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 1, 8, 0, 0, 0));
        tab.push_back(v(0, 4, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
        tab.push_back(v(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        foreach (tab[k]) cyc("table", tab[k].r, tab[k].s, tab[k].i, 1'b1, tab[k].e);

        // illegal code, then sticky error across 20 legal passes
        cyc("ill_rst", 1'b1, 3'd5, 1'b0, 1'b0, '0);
        step("ill", 3'd5);
        step("ill", 3'd0);
        step("ill", 3'd7);
        chk("ill_enables", {load_en, bf_en, out_en, scale_en}, 0);
        chk("ill_span_tw", {span, tw_base}, 0);
        chk("ill_err", seq_err, 1);
        for (int p = 0; p < 20; p++)
            for (int s = 5; s < 11; s++) step("ill_pass", 3'((s == 5) ? 5 : s - 6));
        step("ill_pass", 3'd5);
        chk("ill_err_held", seq_err, 1);
        chk("ill_tx", tx_count, 20);

        // reset in the middle of a transform
        cyc("mid_rst", 1'b1, 3'd5, 1'b0, 1'b0, '0);
        step("mid", 3'd5);
        step("mid", 3'd0);
        step("mid", 3'd1);
        cyc("mid_rst2", 1'b1, 3'd2, 1'b0, 1'b0, '0);
        chk("mid_prev", dut.prev_state, 5);
        chk("mid_tx", tx_count, 0);
        chk("mid_done", done, 0);
        step("mid_unarmed", 3'd2);
        step("mid_unarmed", 3'd3);
        chk("mid_err", seq_err, 0);

        // counter wrap over 256 forward passes
        cyc("wrap_rst", 1'b1, 3'd5, 1'b0, 1'b0, '0);
        step("wrap", 3'd5);
        for (int p = 0; p < 256; p++) begin
            for (int s = 0; s < 5; s++) step("wrap", 3'(s));
            if (p == 255) chk("wrap_pre", tx_count, 255);
            step("wrap", 3'd5);
        end
        chk("wrap_done", done, 1);
        chk("wrap_tx", tx_count, 0);
        chk("wrap_err", seq_err, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
